// File: rtl/mem_responder_if.sv
// Processor and loader signals for one memory responder.
// master: the side that issues requests and streams program bytes.
// slave: the responder.
interface mem_responder_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] rdaddress;
   logic             rden;
   logic [WIDTH-1:0] wraddress;
   logic             wren;
   logic [WIDTH-1:0] q;
   logic             load_start;
   logic             load_valid;
   logic [7:0]       load_byte;
   logic             load_last;
   logic             load_ready;
   logic             busy;
   logic [WIDTH-1:0] load_count;
   logic             oob_error;

   modport master (
      output data, rdaddress, rden, wraddress, wren,
      output load_start, load_valid, load_byte, load_last,
      input  q, load_ready, busy, load_count, oob_error
   );

   modport slave (
      input  data, rdaddress, rden, wraddress, wren,
      input  load_start, load_valid, load_byte, load_last,
      output q, load_ready, busy, load_count, oob_error
   );
endinterface

// File: rtl/mem_responder.sv
// Single-clock word RAM with a 1-cycle registered read port, write-first
// forwarding, and a byte-stream loader that fills the RAM from word 0 upward
// while the processor is held off. Out-of-range accesses set a sticky flag.
module mem_responder #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256
) (
   input  logic           clock,
   input  logic           reset,
   mem_responder_if.slave bus
);
   localparam int NB = WIDTH / 8;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [WIDTH-1:0] DEPTH_W   = WIDTH'(DEPTH);
   localparam logic [BW-1:0]    LAST_BYTE = BW'(NB - 1);

   typedef enum logic {S_IDLE, S_LOAD} state_t;

   logic [WIDTH-1:0] mem [DEPTH];

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;      // doubles as the loader's word pointer
   logic [WIDTH-1:0] asm_q, asm_d;      // partially assembled loader word
   logic [BW-1:0]    bidx_q, bidx_d;
   logic             oob_q, oob_d;

   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] word_new;
   logic             rd_in_range, wr_in_range, fwd, load_acc, word_done;
   logic             ready_o, busy_o;

   // Full-width range checks: no address wraps onto a valid word.
   assign rd_in_range = (bus.rdaddress < DEPTH_W);
   assign wr_in_range = (bus.wraddress < DEPTH_W);
   assign fwd         = bus.wren && wr_in_range && (bus.wraddress == bus.rdaddress);
   assign load_acc    = (state_q == S_LOAD) && bus.load_valid;
   assign word_done   = (bidx_q == LAST_BYTE) || bus.load_last;

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state: load_start opens a session, an accepted last byte closes it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.load_start) state_d = S_LOAD;
         S_LOAD:  if (load_acc && bus.load_last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: the loader is always ready while a session is open.
   always_comb begin
      ready_o = 1'b0;
      busy_o  = 1'b0;
      if (state_q == S_LOAD) begin
         ready_o = 1'b1;
         busy_o  = 1'b1;
      end
   end

   // Datapath next state: processor port in IDLE, byte assembly in LOAD.
   always_comb begin
      rdata_d   = rdata_q;
      cnt_d     = cnt_q;
      asm_d     = asm_q;
      bidx_d    = bidx_q;
      oob_d     = oob_q;
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      // Upper lanes of asm_q are still zero, which pads a short final word.
      word_new  = asm_q;
      for (int k = 0; k < NB; k++) begin
         if (bidx_q == BW'(k)) word_new[8*k +: 8] = bus.load_byte;
      end

      if (state_q == S_IDLE) begin
         if (bus.wren) begin
            if (wr_in_range) begin
               mem_we    = 1'b1;
               mem_waddr = bus.wraddress[AW-1:0];
               mem_wdata = bus.data;
            end else begin
               oob_d = 1'b1;
            end
         end
         if (bus.rden) begin
            if (rd_in_range) begin
               rdata_d = fwd ? bus.data : mem[bus.rdaddress[AW-1:0]];
            end else begin
               rdata_d = '0;
               oob_d   = 1'b1;
            end
         end
         if (bus.load_start) begin
            cnt_d  = '0;
            asm_d  = '0;
            bidx_d = '0;
         end
      end else if (load_acc) begin
         // Past the end of the RAM bytes are swallowed but flagged.
         if (cnt_q >= DEPTH_W) oob_d = 1'b1;
         if (word_done) begin
            asm_d  = '0;
            bidx_d = '0;
            if (cnt_q < DEPTH_W) begin
               mem_we    = 1'b1;
               mem_waddr = cnt_q[AW-1:0];
               mem_wdata = word_new;
               cnt_d     = cnt_q + WIDTH'(1);
            end
         end else begin
            asm_d  = word_new;
            bidx_d = bidx_q + BW'(1);
         end
      end
   end

   // Datapath registers; RAM contents are deliberately outside reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         rdata_q <= '0;
         cnt_q   <= '0;
         asm_q   <= '0;
         bidx_q  <= '0;
         oob_q   <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         bidx_q  <= bidx_d;
         oob_q   <= oob_d;
      end
   end

   // Single RAM write port shared by processor writes and loader words.
   always_ff @(posedge clock) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign bus.q          = rdata_q;
   assign bus.load_ready = ready_o;
   assign bus.busy       = busy_o;
   assign bus.load_count = cnt_q;
   assign bus.oob_error  = oob_q;
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   always #5 clk = ~clk;

   mem_responder_if #(.WIDTH(W)) ifa ();
   mem_responder_if #(.WIDTH(W)) ifb ();

   mem_responder #(.WIDTH(W), .DEPTH(256)) dut_a (.clock(clk), .reset(rst_a), .bus(ifa.slave));
   mem_responder #(.WIDTH(W), .DEPTH(2))   dut_b (.clock(clk), .reset(rst_b), .bus(ifb.slave));

   int checks_total = 0;
   int checks_pass  = 0;

   typedef struct {
      bit         rst;
      bit         rden;
      logic [W-1:0] ra;
      bit         wren;
      logic [W-1:0] wa;
      logic [W-1:0] wd;
      logic [W-1:0] eq;
      bit         eoob;
   } vec_t;

   vec_t vecs[16];

   // reference model state for dut_a
   logic [W-1:0] m_mem [256];
   bit           m_valid [256];
   bit           m_busy;
   int           m_count;
   bit           m_oob;
   logic [W-1:0] m_q;
   bit           m_qk;
   byte unsigned m_sess[$];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks_total++;
      if (act === exp) checks_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      ifa.rden = 0; ifa.rdaddress = '0; ifa.wren = 0; ifa.wraddress = '0; ifa.data = '0;
      ifa.load_start = 0; ifa.load_valid = 0; ifa.load_byte = '0; ifa.load_last = 0;
   endtask

   task automatic idle_b();
      ifb.rden = 0; ifb.rdaddress = '0; ifb.wren = 0; ifb.wraddress = '0; ifb.data = '0;
      ifb.load_start = 0; ifb.load_valid = 0; ifb.load_byte = '0; ifb.load_last = 0;
   endtask

   task automatic a_byte(input logic [7:0] b, input bit last);
      ifa.load_valid = 1; ifa.load_byte = b; ifa.load_last = last;
      step();
      ifa.load_valid = 0; ifa.load_last = 0;
   endtask

   task automatic b_byte(input logic [7:0] b, input bit last);
      ifb.load_valid = 1; ifb.load_byte = b; ifb.load_last = last;
      step();
      ifb.load_valid = 0; ifb.load_last = 0;
   endtask

   task automatic a_start();
      ifa.load_start = 1;
      step();
      ifa.load_start = 0;
   endtask

   task automatic a_read(input logic [W-1:0] addr, output logic [W-1:0] v);
      ifa.rden = 1; ifa.rdaddress = addr;
      step();
      ifa.rden = 0;
      v = ifa.q;
   endtask

   task automatic b_read(input logic [W-1:0] addr, output logic [W-1:0] v);
      ifb.rden = 1; ifb.rdaddress = addr;
      step();
      ifb.rden = 0;
      v = ifb.q;
   endtask

   task automatic model_reset();
      m_busy = 0; m_count = 0; m_oob = 0; m_q = '0; m_qk = 1;
      m_sess.delete();
   endtask

   // One clock of the expected behaviour, from the current inputs of ifa.
   task automatic model_step();
      int n;
      int w;
      logic [W-1:0] word;
      if (!m_busy) begin
         if (ifa.rden) begin
            if (ifa.rdaddress < 256) begin
               if (ifa.wren && ifa.wraddress == ifa.rdaddress) begin
                  m_q = ifa.data; m_qk = 1;
               end else begin
                  m_q = m_mem[ifa.rdaddress[7:0]]; m_qk = m_valid[ifa.rdaddress[7:0]];
               end
            end else begin
               m_q = '0; m_qk = 1; m_oob = 1;
            end
         end
         if (ifa.wren) begin
            if (ifa.wraddress < 256) begin
               m_mem[ifa.wraddress[7:0]] = ifa.data;
               m_valid[ifa.wraddress[7:0]] = 1;
            end else begin
               m_oob = 1;
            end
         end
         if (ifa.load_start) begin
            m_busy = 1; m_count = 0; m_sess.delete();
         end
      end else if (ifa.load_valid) begin
         m_sess.push_back(ifa.load_byte);
         n = m_sess.size();
         if (n - 1 >= 256 * 4) m_oob = 1;
         if ((n % 4) == 0 || ifa.load_last) begin
            w = (n - 1) / 4;
            if (w < 256) begin
               word = '0;
               for (int k = 0; k < 4; k++)
                  if (w * 4 + k < n) word[8*k +: 8] = m_sess[w * 4 + k];
               m_mem[w] = word; m_valid[w] = 1; m_count = w + 1;
            end
         end
         if (ifa.load_last) m_busy = 0;
      end
   endtask

   function automatic logic [W-1:0] pick_addr();
      int r;
      r = $urandom_range(0, 59);
      if (r == 0) return W'(256 + $urandom_range(0, 1000));
      if (r == 1) return W'($urandom) | 32'h8000_0000;
      return W'($urandom_range(0, 15));
   endfunction

   initial begin
      logic [W-1:0] v;

      vecs[0]  = '{1, 0, 0, 0, 0, 0, 32'h0, 0};
      vecs[1]  = '{0, 0, 0, 1, 5, 32'hDEADBEEF, 32'h0, 0};
      vecs[2]  = '{0, 0, 0, 1, 0, 32'hA5A5A5A5, 32'h0, 0};
      vecs[3]  = '{0, 1, 5, 0, 0, 0, 32'hDEADBEEF, 0};
      vecs[4]  = '{0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0};
      vecs[5]  = '{0, 1, 7, 1, 7, 32'h12345678, 32'h12345678, 0};
      vecs[6]  = '{0, 1, 5, 0, 0, 0, 32'hDEADBEEF, 0};
      vecs[7]  = '{0, 1, 7, 0, 0, 0, 32'h12345678, 0};
      vecs[8]  = '{0, 0, 0, 1, 256, 32'hFFFFFFFF, 32'h12345678, 1};
      vecs[9]  = '{0, 1, 0, 0, 0, 0, 32'hA5A5A5A5, 1};
      vecs[10] = '{0, 1, 300, 0, 0, 0, 32'h0, 1};
      vecs[11] = '{0, 1, 5, 1, 32'h105, 32'h11111111, 32'hDEADBEEF, 1};
      vecs[12] = '{0, 1, 5, 0, 0, 0, 32'hDEADBEEF, 1};
      vecs[13] = '{0, 1, 32'h80000007, 0, 0, 0, 32'h0, 1};
      vecs[14] = '{0, 1, 7, 0, 0, 0, 32'h12345678, 1};
      vecs[15] = '{1, 0, 0, 0, 0, 0, 32'h0, 0};

      idle_a(); idle_b();
      rst_a = 1; rst_b = 1;
      step(); step();

      // table-driven processor port vectors
      for (int i = 0; i < 16; i++) begin
         rst_a = vecs[i].rst;
         ifa.rden = vecs[i].rden; ifa.rdaddress = vecs[i].ra;
         ifa.wren = vecs[i].wren; ifa.wraddress = vecs[i].wa; ifa.data = vecs[i].wd;
         step();
         check($sformatf("vec%0d_q", i), ifa.q, vecs[i].eq);
         check($sformatf("vec%0d_oob", i), W'(ifa.oob_error), W'(vecs[i].eoob));
         if (vecs[i].rst) begin
            check($sformatf("vec%0d_busy", i), W'(ifa.busy), 0);
            check($sformatf("vec%0d_ready", i), W'(ifa.load_ready), 0);
            check($sformatf("vec%0d_count", i), ifa.load_count, 0);
         end
      end
      rst_a = 0;
      idle_a();

      // full two-word load, with processor traffic that must be ignored
      a_start();
      check("load_busy", W'(ifa.busy), 1);
      check("load_ready", W'(ifa.load_ready), 1);
      check("load_count0", ifa.load_count, 0);
      ifa.rden = 1; ifa.rdaddress = 300; ifa.wren = 1; ifa.wraddress = 300;
      a_byte(8'h13, 0); a_byte(8'h00, 0); a_byte(8'h50, 0); a_byte(8'h00, 0);
      check("load_count1", ifa.load_count, 1);
      a_byte(8'h93, 0); a_byte(8'h00, 0); a_byte(8'hA0, 0); a_byte(8'h00, 1);
      ifa.rden = 0; ifa.wren = 0;
      check("load_done_busy", W'(ifa.busy), 0);
      check("load_done_ready", W'(ifa.load_ready), 0);
      check("load_done_count", ifa.load_count, 2);
      check("load_ignored_oob", W'(ifa.oob_error), 0);
      check("load_q_held", ifa.q, 0);
      a_read(0, v); check("load_mem0", v, 32'h00500013);
      a_read(1, v); check("load_mem1", v, 32'h00A00093);

      // partial final word
      a_start();
      for (int i = 1; i <= 6; i++) a_byte(8'(i), i == 6);
      check("part_count", ifa.load_count, 2);
      check("part_busy", W'(ifa.busy), 0);
      a_read(0, v); check("part_mem0", v, 32'h04030201);
      a_read(1, v); check("part_mem1", v, 32'h00000605);

      // last on a word boundary writes no extra word
      a_start();
      a_byte(8'h11, 0); a_byte(8'h22, 0); a_byte(8'h33, 0); a_byte(8'h44, 1);
      check("exact_count", ifa.load_count, 1);
      a_read(0, v); check("exact_mem0", v, 32'h44332211);
      a_read(1, v); check("exact_mem1", v, 32'h00000605);

      // load_start together with processor requests
      ifa.load_start = 1; ifa.wren = 1; ifa.wraddress = 10; ifa.data = 32'h0BADC0DE;
      ifa.rden = 1; ifa.rdaddress = 5;
      step();
      idle_a();
      check("simul_q", ifa.q, 32'hDEADBEEF);
      check("simul_busy", W'(ifa.busy), 1);
      a_byte(8'h77, 1);
      check("simul_count", ifa.load_count, 1);
      a_read(10, v); check("simul_mem10", v, 32'h0BADC0DE);
      a_read(0, v);  check("simul_mem0", v, 32'h00000077);

      // reset in the middle of a load
      ifa.wren = 1; ifa.wraddress = 1; ifa.data = 32'hCAFEF00D;
      step();
      ifa.wren = 0;
      a_start();
      for (int i = 0; i < 5; i++) a_byte(8'hA1 + 8'(i), 0);
      check("mid_count", ifa.load_count, 1);
      rst_a = 1; step(); rst_a = 0;
      check("rst_busy", W'(ifa.busy), 0);
      check("rst_ready", W'(ifa.load_ready), 0);
      check("rst_count", ifa.load_count, 0);
      a_read(0, v); check("rst_mem0", v, 32'hA4A3A2A1);
      a_read(1, v); check("rst_mem1", v, 32'hCAFEF00D);

      // overflow on the two-word instance
      rst_b = 0;
      check("b_oob_init", W'(ifb.oob_error), 0);
      ifb.load_start = 1; step(); ifb.load_start = 0;
      for (int i = 1; i <= 12; i++) begin
         b_byte(8'(i), i == 12);
         if (i == 8) begin
            check("b_count_full", ifb.load_count, 2);
            check("b_oob_full", W'(ifb.oob_error), 0);
         end
         if (i == 9) check("b_oob_over", W'(ifb.oob_error), 1);
      end
      check("b_count_end", ifb.load_count, 2);
      check("b_oob_end", W'(ifb.oob_error), 1);
      check("b_busy_end", W'(ifb.busy), 0);
      b_read(0, v); check("b_mem0", v, 32'h04030201);
      b_read(1, v); check("b_mem1", v, 32'h08070605);

      // randomized traffic against the reference model
      idle_a();
      rst_a = 1; step(); rst_a = 0;
      model_reset();
      for (int i = 0; i < 256; i++) m_valid[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         ifa.rden = 1'($urandom_range(0, 1));
         ifa.rdaddress = pick_addr();
         ifa.wren = 1'($urandom_range(0, 1));
         ifa.wraddress = ($urandom_range(0, 3) == 0) ? ifa.rdaddress : pick_addr();
         ifa.data = $urandom;
         ifa.load_start = ($urandom_range(0, 19) == 0);
         ifa.load_valid = ($urandom_range(0, 3) != 0);
         ifa.load_byte = 8'($urandom);
         ifa.load_last = ($urandom_range(0, 11) == 0);
         rst_a = ($urandom_range(0, 199) == 0);
         if (rst_a) model_reset();
         else       model_step();
         step();
         if (m_qk) check("rnd_q", ifa.q, m_q);
         check("rnd_busy", W'(ifa.busy), W'(m_busy));
         check("rnd_ready", W'(ifa.load_ready), W'(m_busy));
         check("rnd_count", ifa.load_count, W'(m_count));
         check("rnd_oob", W'(ifa.oob_error), W'(m_oob));
      end
      rst_a = 0;
      idle_a();

      $display("%0d/%0d checks passed", checks_pass, checks_total);
      $finish;
   end
endmodule
